// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding; the fetch-side
// RAM imports the same widths so both ports agree on geometry.
package imem_pkg;
  localparam int INSTR_W     = 9;
  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    INS_LO = 3'd3,
    INS_HI = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the loader plus the instruction RAM write port it drives.
interface imem_loader_if #(parameter int ADDR_W = imem_pkg::IMEM_ADDR_W);
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                byte_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  imem_pkg::instr_t    wr_data;

  // slave: the loader (stream sink, RAM write master); master: source + RAM side
  modport slave  (input  byte_valid, byte_data,
                  output byte_ready, wr_en, wr_addr, wr_data);
  modport master (output byte_valid, byte_data,
                  input  byte_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: header gives instruction count N, then 2 bytes per
// 9-bit instruction written sequentially from address 0; holds the CPU while busy.
module imem_loader import imem_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   instr_count
);
  localparam int            CW    = ADDR_W + 1;
  localparam logic [13:0]   MAX_N = 14'(1 << ADDR_W);

  loader_state_e      state_q, state_d;
  logic [7:0]         lo_q, lo_d;
  logic [CW-1:0]      n_q, n_d, cnt_q, cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  instr_t             wr_data_q, wr_data_d;

  logic        active, accept, start_ok, hdr_bad, ins_bad, last_ins;
  logic [12:0] hdr_n;

  assign active   = state_q inside {HDR_LO, HDR_HI, INS_LO, INS_HI};
  assign accept   = bus.byte_valid && active;
  assign start_ok = start && (state_q inside {IDLE, DONE, ERROR});
  assign hdr_n    = {bus.byte_data[4:0], lo_q};
  assign hdr_bad  = (bus.byte_data[7:5] != 3'd0) || (hdr_n == 13'd0) ||
                    ({1'b0, hdr_n} > MAX_N);
  assign ins_bad  = bus.byte_data[7:1] != 7'd0;
  assign last_ins = (cnt_q + CW'(1)) == n_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start)  state_d = HDR_LO;
      HDR_LO:            if (accept) state_d = HDR_HI;
      HDR_HI:            if (accept) state_d = hdr_bad ? ERROR : INS_LO;
      INS_LO:            if (accept) state_d = INS_HI;
      INS_HI:            if (accept) state_d = ins_bad  ? ERROR :
                                               last_ins ? DONE  : INS_LO;
      default:           state_d = IDLE;
    endcase
  end

  // Status decodes straight from state; the write port is registered so the
  // final strobe lands in the same cycle DONE first shows.
  always_comb begin
    busy           = active;
    cpu_hold       = active;
    bus.byte_ready = active;
    done           = state_q == DONE;
    error          = state_q == ERROR;

    lo_d      = lo_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (start_ok) cnt_d = '0;
    if (accept) begin
      case (state_q)
        HDR_LO, INS_LO: lo_d = bus.byte_data;
        HDR_HI:         n_d  = CW'(hdr_n);
        INS_HI: if (!ins_bad) begin
          // instruction count doubles as the sequential write address
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = {bus.byte_data[0], lo_q};
          cnt_d     = cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q      <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      lo_q      <= lo_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame vector table plus stall, full-depth and
// mid-load reset sequences, with a write-port logger.
module tb_imem_loader;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, cpu_hold, done, error;
  logic [12:0] instr_count;

  imem_loader_if bus();

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, cyc = 0, hold_bad = 0;
  logic [11:0] log_a[$];
  logic [8:0]  log_d[$];
  int          log_c[$];
  logic        log_f[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cpu_hold !== busy) hold_bad <= hold_bad + 1;
    if (bus.wr_en === 1'b1) begin
      log_a.push_back(bus.wr_addr);
      log_d.push_back(bus.wr_data);
      log_c.push_back(cyc);
      log_f.push_back(done && !busy);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_c.delete(); log_f.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    logic r;
    bus.byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    do begin
      @(negedge clk); r = bus.byte_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 20);
    bus.byte_valid = 1'b0;
    if (!r) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  typedef struct packed {
    logic [3:0]      nb;     // bytes in stream
    logic [63:0]     b;      // stream, first byte in [63:56]
    logic [1:0]      nw;     // expected writes
    logic [2:0][8:0] wd;     // expected data, wd[0] first
    logic            e_done;
    logic            e_err;
    logic [12:0]     e_cnt;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    vecs[0] = '{nb:4'd8, b:64'h0300_FF01_1200_0001, nw:2'd3,
                wd:{9'h100, 9'h012, 9'h1FF}, e_done:1'b1, e_err:1'b0, e_cnt:13'd3};
    vecs[1] = '{nb:4'd2, b:64'h0000_0000_0000_0000, nw:2'd0,
                wd:27'd0, e_done:1'b0, e_err:1'b1, e_cnt:13'd0};
    vecs[2] = '{nb:4'd2, b:64'h0110_0000_0000_0000, nw:2'd0,
                wd:27'd0, e_done:1'b0, e_err:1'b1, e_cnt:13'd0};
    vecs[3] = '{nb:4'd2, b:64'h0120_0000_0000_0000, nw:2'd0,
                wd:27'd0, e_done:1'b0, e_err:1'b1, e_cnt:13'd0};
    vecs[4] = '{nb:4'd6, b:64'h0200_AA00_5503_0000, nw:2'd1,
                wd:{9'h000, 9'h000, 9'h0AA}, e_done:1'b0, e_err:1'b1, e_cnt:13'd1};
    vecs[5] = '{nb:4'd4, b:64'h0100_3401_0000_0000, nw:2'd1,
                wd:{9'h000, 9'h000, 9'h134}, e_done:1'b1, e_err:1'b0, e_cnt:13'd1};
    vecs[6] = '{nb:4'd6, b:64'h0200_0000_FF00_0000, nw:2'd2,
                wd:{9'h000, 9'h0FF, 9'h000}, e_done:1'b1, e_err:1'b0, e_cnt:13'd2};

    // reset state
    #12;
    chk("rst_flags", {busy, cpu_hold, done, error, bus.byte_ready, bus.wr_en}, 32'd0);
    chk("rst_bus", {bus.wr_addr, bus.wr_data, instr_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      clear_log();
      pulse_start();
      chk($sformatf("v%0d_start", v), {busy, bus.byte_ready, done, error}, 4'b1100);
      for (int i = 0; i < int'(vecs[v].nb); i++)
        send_byte(vecs[v].b[63-8*i -: 8], 0);
      chk($sformatf("v%0d_flags_t1", v), {busy, done, error},
          {1'b0, vecs[v].e_done, vecs[v].e_err});
      repeat (3) begin @(posedge clk); #1; end
      chk($sformatf("v%0d_nwr", v), log_d.size(), vecs[v].nw);
      for (int i = 0; i < log_d.size() && i < int'(vecs[v].nw); i++) begin
        chk($sformatf("v%0d_wd%0d", v, i), log_d[i], vecs[v].wd[i]);
        chk($sformatf("v%0d_wa%0d", v, i), log_a[i], i);
        if (i > 0) chk($sformatf("v%0d_gap%0d", v, i), log_c[i] - log_c[i-1], 2);
      end
      chk($sformatf("v%0d_done_err", v), {done, error, busy},
          {vecs[v].e_done, vecs[v].e_err, 1'b0});
      chk($sformatf("v%0d_cnt", v), instr_count, vecs[v].e_cnt);
      if (vecs[v].e_done && log_f.size() > 0)
        chk($sformatf("v%0d_done_with_last_wr", v), log_f[log_f.size()-1], 1);
    end

    // random stalls on the N=3 stream, with a start pulse while busy
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) pulse_start();
      send_byte(vecs[0].b[63-8*i -: 8], $urandom_range(0, 5));
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("gap_nwr", log_d.size(), 3);
    for (int i = 0; i < log_d.size() && i < 3; i++) begin
      chk($sformatf("gap_wd%0d", i), log_d[i], vecs[0].wd[i]);
      chk($sformatf("gap_wa%0d", i), log_a[i], i);
    end
    chk("gap_done_cnt", {done, error, instr_count}, {1'b1, 1'b0, 13'd3});

    // full-depth load: instruction i carries value i[8:0]
    begin
      int bad;
      logic [12:0] iv;
      clear_log();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h10, 0);
      for (int i = 0; i < 4096; i++) begin
        iv = 13'(i);
        send_byte(iv[7:0], 0);
        send_byte({7'd0, iv[8]}, 0);
      end
      repeat (3) begin @(posedge clk); #1; end
      chk("full_nwr", log_d.size(), 4096);
      bad = 0;
      for (int i = 0; i < log_d.size(); i++) begin
        iv = 13'(i);
        if (log_a[i] !== iv[11:0] || log_d[i] !== iv[8:0]) bad++;
      end
      chk("full_contents_bad", bad, 0);
      if (log_a.size() > 0) chk("full_last_addr", log_a[log_a.size()-1], 12'hFFF);
      chk("full_done_cnt", {done, error, instr_count}, {1'b1, 1'b0, 13'd4096});
    end

    // async reset after INS_LO, then reload from address 0
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h34, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_flags", {busy, cpu_hold, done, error, bus.byte_ready, bus.wr_en}, 32'd0);
    chk("midrst_bus", {bus.wr_addr, bus.wr_data, instr_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midrst_no_wr", log_d.size(), 0);
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h56, 0);
    send_byte(8'h01, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("reload_nwr", log_d.size(), 1);
    if (log_d.size() > 0) chk("reload_wr", {log_a[0], log_d[0]}, {12'h000, 9'h156});
    chk("reload_done_cnt", {done, error, instr_count}, {1'b1, 1'b0, 13'd1});

    chk("cpu_hold_eq_busy", hold_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
